// File: rtl/pdl_pkg.sv
// Shared types and constants for the PDL pointer unit.
// Holds the default pointer width, the address type and the reset-limit helper.
package pdl_pkg;

  localparam int PDL_PTR_W = 10;

  typedef logic [PDL_PTR_W-1:0] pdl_addr_t;

  // All-ones value of the given width, used as the power-on limit.
  function automatic logic [31:0] pdl_lim_reset(input int unsigned w);
    if (w >= 32'd32) begin
      pdl_lim_reset = 32'hFFFF_FFFF;
    end else begin
      pdl_lim_reset = (32'd1 << w) - 32'd1;
    end
  endfunction

endpackage

// File: rtl/pdl_pointer_unit_if.sv
// Bus bundle between the micro-sequencer and the PDL pointer unit.
// The master drives phases and controls; the slave returns registers, strobes and flags.
import pdl_pkg::*;

interface pdl_pointer_unit_if #(
  parameter int PTR_W = PDL_PTR_W
);
  logic             state_alu;
  logic             state_write;
  logic             state_fetch;
  logic             state_read;
  logic [31:0]      ob;
  logic             destpdlp;
  logic             destpdlx;
  logic             destpdll;
  logic             destpdlc;
  logic             pdlcnt;
  logic             srcpdlpop;
  logic             srcpdlidx;
  logic             srcpdlptr;
  logic             srcpdlidxinc;
  logic [PTR_W-1:0] pdlptr;
  logic [PTR_W-1:0] pdlidx;
  logic [PTR_W-1:0] pdllim;
  logic             pidrive;
  logic             ppdrive;
  logic             pdl_ovf;
  logic             pdl_unf;
  logic             pdl_trap;

  modport master (
    output state_alu, state_write, state_fetch, state_read, ob,
           destpdlp, destpdlx, destpdll, destpdlc, pdlcnt,
           srcpdlpop, srcpdlidx, srcpdlptr, srcpdlidxinc,
    input  pdlptr, pdlidx, pdllim, pidrive, ppdrive, pdl_ovf, pdl_unf, pdl_trap
  );

  modport slave (
    input  state_alu, state_write, state_fetch, state_read, ob,
           destpdlp, destpdlx, destpdll, destpdlc, pdlcnt,
           srcpdlpop, srcpdlidx, srcpdlptr, srcpdlidxinc,
    output pdlptr, pdlidx, pdllim, pidrive, ppdrive, pdl_ovf, pdl_unf, pdl_trap
  );

endinterface

// File: rtl/pdl_bound_check.sv
// Overflow/underflow detection on the pre-update pointer, with sticky flags
// and a registered one-cycle trap pulse on each fresh 0->1 flag transition.
import pdl_pkg::*;

module pdl_bound_check #(
  parameter int PTR_W = PDL_PTR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clr,
  input  logic [PTR_W-1:0] i_ptr,
  input  logic [PTR_W-1:0] i_lim,
  output logic             o_ovf,
  output logic             o_unf,
  output logic             o_trap
);

  logic w_set_ovf;
  logic w_set_unf;
  logic r_ovf;
  logic r_unf;
  logic r_trap;

  assign w_set_ovf = i_push & (i_ptr == i_lim);
  assign w_set_unf = i_pop & (i_ptr == {PTR_W{1'b0}});

  // A set in the same cycle as a clear wins; a set on an already-set flag does not pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      r_trap <= 1'b0;
    end else begin
      r_ovf  <= w_set_ovf | (r_ovf & ~i_clr);
      r_unf  <= w_set_unf | (r_unf & ~i_clr);
      r_trap <= (w_set_ovf & ~r_ovf) | (w_set_unf & ~r_unf);
    end
  end

  assign o_ovf  = r_ovf;
  assign o_unf  = r_unf;
  assign o_trap = r_trap;

endmodule

// File: rtl/pdl_pointer_unit.sv
// PDL pointer, index and limit registers with push/pop counting, optional
// index post-increment and bound checking; feeds the PDL RAM address mux.
import pdl_pkg::*;

module pdl_pointer_unit #(
  parameter int          PTR_W       = PDL_PTR_W,
  parameter int          IDX_AUTOINC = 1,
  parameter logic [31:0] LIM_RESET   = pdl_lim_reset(PTR_W)
) (
  input  logic                clk,
  input  logic                reset,
  pdl_pointer_unit_if.slave   bus
);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_idx;
  logic [PTR_W-1:0] r_lim;
  logic [PTR_W-1:0] w_ob;
  logic [PTR_W-1:0] w_one;
  logic             w_drive_phase;
  logic             w_push;
  logic             w_pop;
  logic             w_ptr_load;
  logic             w_idx_load;
  logic             w_idx_inc;
  logic             w_lim_load;
  logic             w_clr;

  assign w_ob          = bus.ob[PTR_W-1:0];
  assign w_one         = {{(PTR_W-1){1'b0}}, 1'b1};
  assign w_drive_phase = bus.state_alu | bus.state_write | bus.state_fetch;

  assign w_push     = bus.state_read & bus.pdlcnt & ~bus.srcpdlpop & ~bus.destpdlp;
  assign w_ptr_load = bus.state_fetch & bus.destpdlp;
  // A pointer load in fetch suppresses the pop that would otherwise happen.
  assign w_pop      = bus.state_fetch & ~bus.destpdlp & bus.pdlcnt & bus.srcpdlpop;
  assign w_idx_load = bus.state_write & bus.destpdlx;
  assign w_idx_inc  = (IDX_AUTOINC != 0) & bus.state_fetch & bus.srcpdlidx & bus.srcpdlidxinc;
  assign w_lim_load = bus.state_write & bus.destpdll;
  assign w_clr      = bus.state_write & bus.destpdlc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= {PTR_W{1'b0}};
      r_idx <= {PTR_W{1'b0}};
      r_lim <= LIM_RESET[PTR_W-1:0];
    end else begin
      if (w_ptr_load) begin
        r_ptr <= w_ob;
      end else if (w_push) begin
        r_ptr <= r_ptr + w_one;
      end else if (w_pop) begin
        r_ptr <= r_ptr - w_one;
      end else begin
        r_ptr <= r_ptr;
      end

      if (w_idx_load) begin
        r_idx <= w_ob;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + w_one;
      end else begin
        r_idx <= r_idx;
      end

      if (w_lim_load) begin
        r_lim <= w_ob;
      end else begin
        r_lim <= r_lim;
      end
    end
  end

  pdl_bound_check #(
    .PTR_W (PTR_W)
  ) u_bound_check (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_clr  (w_clr),
    .i_ptr  (r_ptr),
    .i_lim  (r_lim),
    .o_ovf  (bus.pdl_ovf),
    .o_unf  (bus.pdl_unf),
    .o_trap (bus.pdl_trap)
  );

  assign bus.pdlptr  = r_ptr;
  assign bus.pdlidx  = r_idx;
  assign bus.pdllim  = r_lim;
  assign bus.pidrive = bus.srcpdlidx & w_drive_phase;
  assign bus.ppdrive = bus.srcpdlptr & w_drive_phase;

endmodule

// File: tb/tb_pdl_pointer_unit.sv
// Instruction-level bench for pdl_pointer_unit: directed plan items, then random
// instructions checked against a behavioural model of the PDL pointer rules.
module tb_pdl_pointer_unit;

  localparam int PTR_W = 10;

  typedef struct {
    logic [31:0] ob;
    logic destpdlp, destpdlx, destpdll, destpdlc, pdlcnt;
    logic srcpdlpop, srcpdlidx, srcpdlptr, srcpdlidxinc, rst_rd;
  } instr_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  // Model state: pointer, index (with and without auto-increment), limit, flags.
  logic [9:0] m_ptr, m_idx, m_idx1, m_lim;
  logic       m_ovf, m_unf;

  pdl_pointer_unit_if #(.PTR_W(PTR_W)) bus0 ();
  pdl_pointer_unit_if #(.PTR_W(PTR_W)) bus1 ();

  pdl_pointer_unit #(.PTR_W(PTR_W), .IDX_AUTOINC(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  pdl_pointer_unit #(.PTR_W(PTR_W), .IDX_AUTOINC(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  always #5 clk = ~clk;

  assign bus1.state_alu    = bus0.state_alu;
  assign bus1.state_write  = bus0.state_write;
  assign bus1.state_fetch  = bus0.state_fetch;
  assign bus1.state_read   = bus0.state_read;
  assign bus1.ob           = bus0.ob;
  assign bus1.destpdlp     = bus0.destpdlp;
  assign bus1.destpdlx     = bus0.destpdlx;
  assign bus1.destpdll     = bus0.destpdll;
  assign bus1.destpdlc     = bus0.destpdlc;
  assign bus1.pdlcnt       = bus0.pdlcnt;
  assign bus1.srcpdlpop    = bus0.srcpdlpop;
  assign bus1.srcpdlidx    = bus0.srcpdlidx;
  assign bus1.srcpdlptr    = bus0.srcpdlptr;
  assign bus1.srcpdlidxinc = bus0.srcpdlidxinc;

  always @(posedge clk) begin
    assert ($countones({bus0.state_alu, bus0.state_write, bus0.state_fetch, bus0.state_read}) <= 1)
      else $error("phase inputs overlap");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t nop();
    instr_t c;
    c.ob = 32'd0;        c.destpdlp = 1'b0;  c.destpdlx = 1'b0;     c.destpdll = 1'b0;
    c.destpdlc = 1'b0;   c.pdlcnt = 1'b0;    c.srcpdlpop = 1'b0;    c.srcpdlidx = 1'b0;
    c.srcpdlptr = 1'b0;  c.srcpdlidxinc = 1'b0; c.rst_rd = 1'b0;
    return c;
  endfunction

  task automatic set_phase(input int ph);
    bus0.state_alu   = (ph == 0);
    bus0.state_write = (ph == 1);
    bus0.state_fetch = (ph == 2);
    bus0.state_read  = (ph == 3);
  endtask

  task automatic model_reset();
    m_ptr = 10'h000; m_idx = 10'h000; m_idx1 = 10'h000; m_lim = 10'h3FF;
    m_ovf = 1'b0;    m_unf = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    check_val({tag, ".ptr"},  bus0.pdlptr,  m_ptr);
    check_val({tag, ".idx"},  bus0.pdlidx,  m_idx);
    check_val({tag, ".idx0"}, bus1.pdlidx,  m_idx1);
    check_val({tag, ".lim"},  bus0.pdllim,  m_lim);
    check_val({tag, ".ovf"},  bus0.pdl_ovf, m_ovf);
    check_val({tag, ".unf"},  bus0.pdl_unf, m_unf);
  endtask

  // One instruction = alu, write, fetch, read cycles with controls held constant.
  task automatic run_instr(input instr_t c);
    logic nf;
    bus0.ob = c.ob;               bus0.destpdlp = c.destpdlp;   bus0.destpdlx = c.destpdlx;
    bus0.destpdll = c.destpdll;   bus0.destpdlc = c.destpdlc;   bus0.pdlcnt = c.pdlcnt;
    bus0.srcpdlpop = c.srcpdlpop; bus0.srcpdlidx = c.srcpdlidx; bus0.srcpdlptr = c.srcpdlptr;
    bus0.srcpdlidxinc = c.srcpdlidxinc;
    for (int ph = 0; ph < 4; ph++) begin
      set_phase(ph);
      if (ph == 3 && c.rst_rd) reset = 1'b1;
      #1;
      check_val("pidrive", bus0.pidrive, c.srcpdlidx && (ph != 3));
      check_val("ppdrive", bus0.ppdrive, c.srcpdlptr && (ph != 3));
      nf = 1'b0;
      case (ph)
        1: begin
          if (c.destpdll) m_lim = c.ob[9:0];
          if (c.destpdlx) begin m_idx = c.ob[9:0]; m_idx1 = c.ob[9:0]; end
          if (c.destpdlc) begin m_ovf = 1'b0; m_unf = 1'b0; end
        end
        2: begin
          if (c.destpdlp) m_ptr = c.ob[9:0];
          else if (c.pdlcnt && c.srcpdlpop) begin
            if (m_ptr == 10'h000) begin nf = !m_unf; m_unf = 1'b1; end
            m_ptr = m_ptr - 10'd1;
          end
          if (c.srcpdlidx && c.srcpdlidxinc) m_idx = m_idx + 10'd1;
        end
        3: begin
          if (c.pdlcnt && !c.srcpdlpop && !c.destpdlp) begin
            if (m_ptr == m_lim) begin nf = !m_ovf; m_ovf = 1'b1; end
            m_ptr = m_ptr + 10'd1;
          end
          if (c.rst_rd) begin model_reset(); nf = 1'b0; end
        end
        default: ;
      endcase
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_val("trap", bus0.pdl_trap, nf);
      check_regs("step");
    end
    set_phase(4);
  endtask

  function automatic instr_t rnd_instr();
    instr_t c;
    logic [31:0] v;
    c = nop();
    v = $urandom;
    case ($urandom_range(0, 3))
      0:       v[9:0] = 10'h000;
      1:       v[9:0] = m_lim;
      2:       v[9:0] = 10'h3FF;
      default: ;
    endcase
    c.ob           = v;
    c.destpdlp     = ($urandom_range(0, 3) == 0);
    c.destpdlx     = ($urandom_range(0, 3) == 0);
    c.destpdll     = ($urandom_range(0, 7) == 0);
    c.destpdlc     = ($urandom_range(0, 7) == 0);
    c.pdlcnt       = ($urandom_range(0, 1) == 0);
    c.srcpdlpop    = ($urandom_range(0, 1) == 0);
    c.srcpdlidx    = ($urandom_range(0, 1) == 0);
    c.srcpdlptr    = ($urandom_range(0, 1) == 0);
    c.srcpdlidxinc = ($urandom_range(0, 1) == 0);
    c.rst_rd       = ($urandom_range(0, 49) == 0);
    // Keep a limit load away from a push in the same instruction.
    if (c.destpdll && c.pdlcnt && !c.srcpdlpop) c.pdlcnt = 1'b0;
    return c;
  endfunction

  initial begin
    instr_t c;
    reset = 1'b1;
    set_phase(4);
    run_ctrl_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_val("rst.ptr",  bus0.pdlptr,   32'h000);
    check_val("rst.idx",  bus0.pdlidx,   32'h000);
    check_val("rst.lim",  bus0.pdllim,   32'h3FF);
    check_val("rst.ovf",  bus0.pdl_ovf,  32'h0);
    check_val("rst.unf",  bus0.pdl_unf,  32'h0);
    check_val("rst.trap", bus0.pdl_trap, 32'h0);

    c = nop(); c.pdlcnt = 1'b1; c.srcpdlptr = 1'b1;
    run_instr(c); check_val("push1", bus0.pdlptr, 32'h001);
    run_instr(c); check_val("push2", bus0.pdlptr, 32'h002);
    run_instr(c); check_val("push3", bus0.pdlptr, 32'h003);
    c.srcpdlpop = 1'b1;
    run_instr(c); check_val("pop1", bus0.pdlptr, 32'h002);

    c = nop(); c.destpdll = 1'b1; c.ob = 32'h5; run_instr(c);
    c = nop(); c.destpdlp = 1'b1; c.ob = 32'h5; run_instr(c);
    c = nop(); c.pdlcnt = 1'b1;
    run_instr(c);
    check_val("ovf.ptr", bus0.pdlptr, 32'h006);
    check_val("ovf.flag", bus0.pdl_ovf, 32'h1);
    run_instr(c); check_val("ovf.ptr2", bus0.pdlptr, 32'h007);

    c = nop(); c.destpdlp = 1'b1; c.ob = 32'h0; run_instr(c);
    c = nop(); c.pdlcnt = 1'b1; c.srcpdlpop = 1'b1; run_instr(c);
    check_val("unf.ptr",  bus0.pdlptr,  32'h3FF);
    check_val("unf.flag", bus0.pdl_unf, 32'h1);
    c = nop(); c.destpdlc = 1'b1; run_instr(c);
    check_val("clr.ovf", bus0.pdl_ovf, 32'h0);
    check_val("clr.unf", bus0.pdl_unf, 32'h0);

    c = nop(); c.destpdlp = 1'b1; c.ob = 32'hFFFF_F123; c.pdlcnt = 1'b1; c.srcpdlpop = 1'b1;
    run_instr(c); check_val("loadpri", bus0.pdlptr, 32'h123);

    c = nop(); c.destpdlx = 1'b1; c.ob = 32'h3FF; c.srcpdlidx = 1'b1; c.srcpdlidxinc = 1'b1;
    run_instr(c);
    check_val("idxwrap", bus0.pdlidx, 32'h000);
    check_val("idxnoinc", bus1.pdlidx, 32'h3FF);

    c = nop(); c.pdlcnt = 1'b1; c.rst_rd = 1'b1; run_instr(c);
    check_val("midrst.ptr", bus0.pdlptr, 32'h000);
    check_val("midrst.lim", bus0.pdllim, 32'h3FF);
    check_val("midrst.idx1", bus1.pdlidx, 32'h000);

    for (int n = 0; n < 400; n++) begin
      c = rnd_instr();
      run_instr(c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic run_ctrl_idle();
    bus0.ob = 32'd0;        bus0.destpdlp = 1'b0;  bus0.destpdlx = 1'b0;  bus0.destpdll = 1'b0;
    bus0.destpdlc = 1'b0;   bus0.pdlcnt = 1'b0;    bus0.srcpdlpop = 1'b0; bus0.srcpdlidx = 1'b0;
    bus0.srcpdlptr = 1'b0;  bus0.srcpdlidxinc = 1'b0;
  endtask

endmodule
